// File: rtl/regarb_pkg.sv
// regarb_pkg: shared types, constants and helpers for the register-file write arbiter
package regarb_pkg;
  typedef enum logic {IDLE, LOCKED} state_e;
  localparam int LOCK_CNT_W = 4;
  // Round-robin successor of idx among n requesters
  function automatic int next_rr(input int idx, input int n);
    return (idx + 1) % n;
  endfunction
endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: pick the first valid requester scanning from ptr upward, modulo N
// Ports: valid_i  request vector
//        ptr_i    round-robin start index
//        grant_o  one-hot grant (zero when nothing is valid)
//        idx_o    index of the granted requester (0 when nothing is valid)
module rr_priority_pick #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o
);
  always_comb begin
    idx_o = '0;
    // Scan from the farthest offset down so the closest valid requester to ptr wins
    for (int k = N - 1; k >= 0; k--)
      if (valid_i[(int'(ptr_i) + k) % N]) idx_o = IW'((int'(ptr_i) + k) % N);
    grant_o = (|valid_i) ? (N'(1) << idx_o) : '0;
  end
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin arbiter with burst lock for the register array write port
// Ports: clk, rst_n (async active-low)
//        reqValid/reqLock/reqAddr/reqData  per-requester write requests (packed slices)
//        reqReady                           one-hot combinational accept
//        wrEnable/dirrInput/inputData       registered write command to the array
//        lockActive                         port held by a locked owner
//        rdAddrN/rdArrN -> rdDataN          read path, forwarded from the pending write
//                                           when REGARB_BYPASS_EN is defined
module regfile_write_arbiter
  import regarb_pkg::*;
#(
  parameter int BITS_DATA = 32,
  parameter int BITS_ADDR = 3,
  parameter int NUM_REQ   = 2,
  parameter int MAX_LOCK  = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             reqValid,
  input  logic [NUM_REQ-1:0]             reqLock,
  input  logic [NUM_REQ*BITS_ADDR-1:0]   reqAddr,
  input  logic [NUM_REQ*BITS_DATA-1:0]   reqData,
  output logic [NUM_REQ-1:0]             reqReady,
  output logic                           wrEnable,
  output logic [BITS_ADDR-1:0]           dirrInput,
  output logic [BITS_DATA-1:0]           inputData,
  output logic                           lockActive,
  input  logic [BITS_ADDR-1:0]           rdAddr1,
  input  logic [BITS_ADDR-1:0]           rdAddr2,
  input  logic [BITS_DATA-1:0]           rdArr1,
  input  logic [BITS_DATA-1:0]           rdArr2,
  output logic [BITS_DATA-1:0]           rdData1,
  output logic [BITS_DATA-1:0]           rdData2
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  state_e                state_q, state_d;
  logic [IW-1:0]         ptr_q, ptr_d, owner_q, owner_d, pick_idx, gidx;
  logic [LOCK_CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_REQ-1:0]    pick_grant;
  logic                  locked, xfer, wr_en_q;
  logic [BITS_ADDR-1:0]  addr_q;
  logic [BITS_DATA-1:0]  data_q;
  rr_priority_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .valid_i(reqValid),
    .ptr_i  (ptr_q),
    .grant_o(pick_grant),
    .idx_o  (pick_idx)
  );
  assign locked   = state_q == LOCKED;
  assign gidx     = locked ? owner_q : pick_idx;
  // While locked only the owner can be accepted, and only if it is still requesting
  assign reqReady = locked ? ({{(NUM_REQ-1){1'b0}}, reqValid[owner_q]} << owner_q) : pick_grant;
  assign xfer     = |reqReady;
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    if (xfer) ptr_d = IW'(next_rr(int'(gidx), NUM_REQ));
    // MAX_LOCK=1 means a single grant already exhausts the lock, so LOCKED is skipped
    if (!locked && xfer && reqLock[gidx] && MAX_LOCK > 1) begin
      state_d = LOCKED;
      owner_d = gidx;
      cnt_d   = LOCK_CNT_W'(1);
    end else if (locked && (!xfer || !reqLock[gidx] || int'(cnt_q) + 1 >= MAX_LOCK)) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (locked) begin
      cnt_d = cnt_q + LOCK_CNT_W'(1);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      wr_en_q <= xfer;
      if (xfer) begin
        addr_q <= reqAddr[gidx*BITS_ADDR +: BITS_ADDR];
        data_q <= reqData[gidx*BITS_DATA +: BITS_DATA];
      end
    end
  end
  assign wrEnable   = wr_en_q;
  assign dirrInput  = addr_q;
  assign inputData  = data_q;
  assign lockActive = locked;
`ifdef REGARB_BYPASS_EN
  // Forward the write being committed this cycle to a read of the same register
  assign rdData1 = (wr_en_q && rdAddr1 == addr_q) ? data_q : rdArr1;
  assign rdData2 = (wr_en_q && rdAddr2 == addr_q) ? data_q : rdArr2;
`else
  assign rdData1 = rdArr1;
  assign rdData2 = rdArr2;
  logic unused_rd;
  assign unused_rd = ^{rdAddr1, rdAddr2};
`endif
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed self-checking bench for regfile_write_arbiter
module tb_regfile_write_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  reqValid = '0, reqLock = '0, reqReady;
  logic [5:0]  reqAddr = '0;
  logic [63:0] reqData = '0;
  logic        wrEnable, lockActive;
  logic [2:0]  dirrInput, rdAddr1 = '0, rdAddr2 = '0;
  logic [31:0] inputData, rdArr1 = '0, rdArr2 = '0, rdData1, rdData2;
  int nvec = 0, nmis = 0;
  always #5 clk = ~clk;
  regfile_write_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .reqValid(reqValid), .reqLock(reqLock), .reqAddr(reqAddr), .reqData(reqData),
    .reqReady(reqReady), .wrEnable(wrEnable), .dirrInput(dirrInput), .inputData(inputData),
    .lockActive(lockActive),
    .rdAddr1(rdAddr1), .rdAddr2(rdAddr2), .rdArr1(rdArr1), .rdArr2(rdArr2),
    .rdData1(rdData1), .rdData2(rdData2)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reqValid = '0;
    reqLock  = '0;
    rst_n    = 1'b0;
    #2;
    rst_n    = 1'b1;
    #1;
  endtask
  initial begin
    logic [1:0] exp_g [6];
    logic       exp_l [6];
    exp_g = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10};
    exp_l = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    reqAddr = {3'd2, 3'd3};
    reqData = {32'hB0B0_0001, 32'hDEAD_BEEF};
    #3;
    check("rst_wren", wrEnable, 0);
    check("rst_addr", dirrInput, 0);
    check("rst_data", inputData, 0);
    check("rst_lock", lockActive, 0);
    rst_n = 1'b1;
    step();
    // single request
    reqValid = 2'b01;
    #1;
    check("t1_ready", reqReady, 2'b01);
    step();
    reqValid = 2'b00;
    check("t1_wren", wrEnable, 1);
    check("t1_addr", dirrInput, 3);
    check("t1_data", inputData, 32'hDEAD_BEEF);
    #1;
    check("t1_idle_ready", reqReady, 0);
    step();
    check("t1_wren_off", wrEnable, 0);
    check("t1_hold_addr", dirrInput, 3);
    // round-robin fairness from ptr=0
    do_reset();
    reqAddr  = {3'd2, 3'd1};
    reqData  = {32'h2222_2222, 32'h1111_1111};
    reqValid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("t2_ready%0d", k), reqReady, (k % 2) ? 2'b10 : 2'b01);
      step();
      check($sformatf("t2_wren%0d", k), wrEnable, 1);
      check($sformatf("t2_addr%0d", k), dirrInput, (k % 2) ? 3'd2 : 3'd1);
    end
    // move ptr to 1 with a lone grant to requester 0, then lock burst by requester 1
    do_reset();
    reqValid = 2'b01;
    step();
    reqValid = 2'b11;
    reqLock  = 2'b10;
    for (int k = 0; k < 6; k++) begin
      #1;
      check($sformatf("t3_ready%0d", k), reqReady, exp_g[k]);
      check($sformatf("t3_lock%0d", k), lockActive, exp_l[k]);
      step();
    end
    check("t3_relock", lockActive, 1);
    // early release: owner transfers once more, then drops valid
    #1;
    check("t4_own_ready", reqReady, 2'b10);
    step();
    reqValid = 2'b01;
    #1;
    check("t4_drop_ready", reqReady, 0);
    step();
    check("t4_no_wr", wrEnable, 0);
    check("t4_unlock", lockActive, 0);
    check("t4_r0_ready", reqReady, 2'b01);
    step();
    check("t4_r0_wr", wrEnable, 1);
    check("t4_r0_addr", dirrInput, 3'd1);
    // requester 0 locks (ptr becomes 1), then async reset between edges
    reqLock = 2'b01;
    step();
    check("t5_lock_on", lockActive, 1);
    check("t5_wren_on", wrEnable, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_wren", wrEnable, 0);
    check("t5_rst_lock", lockActive, 0);
    #1;
    rst_n    = 1'b1;
    reqLock  = 2'b00;
    reqValid = 2'b11;
    #1;
    check("t5_first_grant", reqReady, 2'b01);
    step();
    // read path
    do_reset();
    reqAddr  = {3'd0, 3'd5};
    reqData  = {32'h0, 32'h1234_5678};
    rdAddr1  = 3'd5;
    rdArr1   = 32'h0;
    rdAddr2  = 3'd4;
    rdArr2   = 32'hCAFE_F00D;
    reqValid = 2'b01;
    #1;
    check("t6_pre_rd1", rdData1, 32'h0);
    step();
    reqValid = 2'b00;
    check("t6_wren", wrEnable, 1);
`ifdef REGARB_BYPASS_EN
    check("t6_byp_rd1", rdData1, 32'h1234_5678);
`else
    check("t6_raw_rd1", rdData1, 32'h0);
`endif
    check("t6_rd2", rdData2, 32'hCAFE_F00D);
    step();
    check("t6_after_rd1", rdData1, 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
